uart_tx_mmio_ctrl: RTL and testbench



---
 rtl/uart_tx_mmio_ctrl_pkg.sv | 26 ++
 rtl/uart_tx_mmio_ctrl_if.sv | 34 +++
 rtl/uart_tx_mmio_ctrl_sync_fifo.sv | 60 ++++++
 rtl/uart_tx_mmio_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_mmio_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_mmio_ctrl_pkg.sv
// Shared types and constants for the memory-mapped UART transmit controller.
//   tx_state_t      : serializer FSM states
//   UART_*_OFS      : register byte offsets within the 16-byte peripheral window
//   CTRL_* / STAT_* : bit positions inside the CTRL and STATUS registers
package uart_tx_mmio_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_t;

  localparam logic [3:0] UART_CTRL_OFS = 4'h0;
  localparam logic [3:0] UART_DATA_OFS = 4'h4;
  localparam logic [3:0] UART_STAT_OFS = 4'h8;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_FLUSH_BIT = 1;

  localparam int unsigned STAT_EMPTY_BIT = 8;
  localparam int unsigned STAT_FULL_BIT  = 9;
  localparam int unsigned STAT_BUSY_BIT  = 10;
  localparam int unsigned STAT_OVF_BIT   = 11;

endpackage

// File: rtl/uart_tx_mmio_ctrl_if.sv
// Core data-bus slice seen by the UART peripheral.
//   mem_addr       : byte address from the core
//   mem_write_en   : store strobe, one cycle per access
//   mem_write_data : store data
//   mem_read_en    : load strobe
//   mem_read_data  : load data, registered, valid the cycle after mem_read_en
// master = core side, slave = peripheral side.
interface uart_tx_mmio_ctrl_if #(
  parameter int unsigned XLEN = 32
) ();

  logic [XLEN-1:0] mem_addr;
  logic            mem_write_en;
  logic [XLEN-1:0] mem_write_data;
  logic            mem_read_en;
  logic [XLEN-1:0] mem_read_data;

  modport master (
    output mem_addr,
    output mem_write_en,
    output mem_write_data,
    output mem_read_en,
    input  mem_read_data
  );

  modport slave (
    input  mem_addr,
    input  mem_write_en,
    input  mem_write_data,
    input  mem_read_en,
    output mem_read_data
  );

endinterface

// File: rtl/uart_tx_mmio_ctrl_sync_fifo.sv
// Single-clock FIFO with flush.
//   clk_i, reset_i : clock, synchronous active-high reset
//   push_i, data_i : write request and data (dropped when full unless popping)
//   pop_i, data_o  : read request, head-of-queue data (show-ahead)
//   flush_i        : empties the FIFO; a push in the same cycle is discarded
//   full_o, empty_o, count_o : occupancy status
module uart_tx_mmio_ctrl_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx_mmio_ctrl.sv
// Memory-mapped UART transmitter (8N1, LSB first) with a TX FIFO.
//   clk_i      : system clock
//   reset_i    : synchronous active-high reset
//   bus        : core data bus (slave modport)
//   tx_o       : UART serial output, idles high
//   tx_busy_o  : frame in progress, or enabled with data pending
// Registers (offset from BASE_ADDR):
//   0x0 CTRL   RW  bit0 tx_en, bit1 flush (self-clearing, reads 0)
//   0x4 DATA   WO  write pushes wdata[7:0]
//   0x8 STATUS RO  [7:0] count, [8] empty, [9] full, [10] busy, [11] overflow (W1C)
//   0xC reserved
module uart_tx_mmio_ctrl
  import uart_tx_mmio_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] BASE_ADDR    = 32'hA000_0000,
  parameter int unsigned     FIFO_DEPTH   = 16,
  parameter int unsigned     CLKS_PER_BIT = 868
) (
  input  logic                clk_i,
  input  logic                reset_i,
  uart_tx_mmio_ctrl_if.slave  bus,
  output logic                tx_o,
  output logic                tx_busy_o
);

  localparam int unsigned CntW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BitCntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // Address decode
  logic       sel;
  logic [3:0] ofs;
  logic       wr, rd;
  logic       ctrl_wr, data_wr, stat_wr;
  logic       flush, ovf_clr;

  assign sel = (bus.mem_addr[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
  assign ofs = {bus.mem_addr[3:2], 2'b00};
  assign wr  = sel && bus.mem_write_en;
  assign rd  = sel && bus.mem_read_en;

  assign ctrl_wr = wr && (ofs == UART_CTRL_OFS);
  assign data_wr = wr && (ofs == UART_DATA_OFS);
  assign stat_wr = wr && (ofs == UART_STAT_OFS);
  assign flush   = ctrl_wr && bus.mem_write_data[CTRL_FLUSH_BIT];
  assign ovf_clr = stat_wr && bus.mem_write_data[STAT_OVF_BIT];

  logic unused_bits;
  assign unused_bits = ^{bus.mem_addr[1:0], bus.mem_write_data};

  // TX FIFO
  logic            fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_data;
  logic [CntW-1:0] fifo_count;

  uart_tx_mmio_ctrl_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (data_wr),
    .data_i  (bus.mem_write_data[7:0]),
    .pop_i   (fifo_pop),
    .flush_i (flush),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Control / overflow registers
  logic tx_en_q;
  logic ovf_q;
  logic ovf_set;

  // Only a push that the FIFO cannot absorb counts as overflow.
  assign ovf_set = data_wr && fifo_full && !fifo_pop;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_en_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (ctrl_wr) tx_en_q <= bus.mem_write_data[CTRL_EN_BIT];
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  // TX serializer
  tx_state_t          state_q;
  logic [BitCntW-1:0] bit_cnt_q;
  logic [2:0]         bit_idx_q;
  logic [7:0]         shreg_q;
  logic               tx_q;
  logic               bit_done;

  assign bit_done = (bit_cnt_q == BitCntW'(CLKS_PER_BIT - 1));

  // Pops happen from IDLE or at the last STOP cycle (back-to-back frames).
  // A pending flush suppresses the pop so no flushed byte ever starts a frame.
  assign fifo_pop = tx_en_q && !fifo_empty && !flush &&
                    ((state_q == StIdle) || ((state_q == StStop) && bit_done));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          bit_cnt_q <= '0;
          if (fifo_pop) begin
            shreg_q <= fifo_data;
            tx_q    <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (bit_done) begin
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            tx_q      <= shreg_q[0];
            state_q   <= StData;
          end else begin
            bit_cnt_q <= bit_cnt_q + BitCntW'(1);
          end
        end
        StData: begin
          if (bit_done) begin
            bit_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              // Shift right so the next bit to send is always at shreg_q[1].
              bit_idx_q <= bit_idx_q + 3'd1;
              shreg_q   <= shreg_q >> 1;
              tx_q      <= shreg_q[1];
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BitCntW'(1);
          end
        end
        StStop: begin
          if (bit_done) begin
            bit_cnt_q <= '0;
            if (fifo_pop) begin
              shreg_q <= fifo_data;
              tx_q    <= 1'b0;
              state_q <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BitCntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_o      = tx_q;
  assign tx_busy_o = (state_q != StIdle) || (tx_en_q && !fifo_empty);

  // Read path: values are sampled before any same-cycle write takes effect.
  logic [XLEN-1:0] status;
  logic [XLEN-1:0] rdata_d, rdata_q;

  always_comb begin
    status                 = '0;
    status[7:0]            = 8'(fifo_count);
    status[STAT_EMPTY_BIT] = fifo_empty;
    status[STAT_FULL_BIT]  = fifo_full;
    status[STAT_BUSY_BIT]  = tx_busy_o;
    status[STAT_OVF_BIT]   = ovf_q;
  end

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      case (ofs)
        UART_CTRL_OFS: rdata_d[CTRL_EN_BIT] = tx_en_q;
        UART_STAT_OFS: rdata_d = status;
        default:       rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign bus.mem_read_data = rdata_q;

endmodule

// File: tb/tb_uart_tx_mmio_ctrl.sv
module tb_uart_tx_mmio_ctrl;

  localparam int unsigned C = 4;
  localparam int unsigned D = 4;
  localparam logic [31:0] A_CTRL = 32'hA000_0000;
  localparam logic [31:0] A_DATA = 32'hA000_0004;
  localparam logic [31:0] A_STAT = 32'hA000_0008;
  localparam logic [31:0] A_RSVD = 32'hA000_000C;

  typedef struct {
    int          at;
    int          kind;  // 0 none, 1 write, 2 read-and-compare
    logic [31:0] addr;
    logic [31:0] data;
  } act_t;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic tx_o, tx_busy_o;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;

  uart_tx_mmio_ctrl_if #(.XLEN(32)) bus ();

  uart_tx_mmio_ctrl #(
    .XLEN         (32),
    .BASE_ADDR    (32'hA000_0000),
    .FIFO_DEPTH   (D),
    .CLKS_PER_BIT (C)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .bus       (bus),
    .tx_o      (tx_o),
    .tx_busy_o (tx_busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.mem_addr = a; bus.mem_write_data = d; bus.mem_write_en = 1'b1;
    tick();
    bus.mem_write_en = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    bus.mem_addr = a; bus.mem_read_en = 1'b1;
    tick();
    bus.mem_read_en = 1'b0;
    chk(tag, bus.mem_read_data, exp);
  endtask

  function automatic act_t mk_act(input int at, input int kind,
                                  input logic [31:0] a, input logic [31:0] d);
    act_t r;
    r.at = at; r.kind = kind; r.addr = a; r.data = d;
    return r;
  endfunction

  // Reference model: a plain byte queue with a sticky overflow flag.
  function automatic logic [31:0] exp_stat(input logic busy);
    logic [31:0] r;
    r = '0;
    r[7:0] = 8'(mq.size());
    r[8]   = (mq.size() == 0);
    r[9]   = (mq.size() == D);
    r[10]  = busy;
    r[11]  = m_ovf;
    return r;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    bus_write(A_DATA, {24'h0, b});
    if (mq.size() < D) mq.push_back(b);
    else m_ovf = 1'b1;
  endtask

  // Enable TX; the frame start bit appears one cycle after CTRL is written.
  task automatic start_tx();
    bus_write(A_CTRL, 32'h1);
    chk("pre_start_tx_high", {31'h0, tx_o}, 32'h1);
    chk("pre_start_busy", {31'h0, tx_busy_o}, 32'h1);
    tick();
  endtask

  // Called on the first cycle of a frame; checks all 10*C cycles of 8N1 output.
  task automatic check_frame(input logic [7:0] b, input string tag,
                             input act_t a0, input act_t a1);
    for (int i = 0; i < 10 * C; i++) begin
      int   bi;
      logic e;
      bi = i / C;
      e  = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
      chk($sformatf("%s_tx_c%0d", tag, i), {31'h0, tx_o}, {31'h0, e});
      if (i == 0) chk($sformatf("%s_busy", tag), {31'h0, tx_busy_o}, 32'h1);
      if (a0.at == i && a0.kind == 1) begin
        bus.mem_addr = a0.addr; bus.mem_write_data = a0.data; bus.mem_write_en = 1'b1;
      end
      if (a0.at == i && a0.kind == 2) begin
        bus.mem_addr = a0.addr; bus.mem_read_en = 1'b1;
      end
      if (a1.at == i && a1.kind == 1) begin
        bus.mem_addr = a1.addr; bus.mem_write_data = a1.data; bus.mem_write_en = 1'b1;
      end
      tick();
      bus.mem_write_en = 1'b0;
      bus.mem_read_en  = 1'b0;
      if (a0.at == i && a0.kind == 2)
        chk($sformatf("%s_rd", tag), bus.mem_read_data, a0.data);
    end
  endtask

  initial begin
    act_t       none;
    logic [7:0] b, e, f;
    int         lows;

    none = mk_act(-1, 0, 32'h0, 32'h0);
    bus.mem_addr = '0; bus.mem_write_en = 1'b0;
    bus.mem_write_data = '0; bus.mem_read_en = 1'b0;

    // Reset
    tick(); tick();
    reset_i = 1'b0;
    chk("rst_tx", {31'h0, tx_o}, 32'h1);
    chk("rst_busy", {31'h0, tx_busy_o}, 32'h0);
    chk("rst_rdata", bus.mem_read_data, 32'h0);
    bus_read(A_STAT, exp_stat(1'b0), "rst_status");
    tick();
    chk("rdata_idle_zero", bus.mem_read_data, 32'h0);
    bus_read(A_CTRL, 32'h0, "rst_ctrl");

    // Two back-to-back frames
    push_byte(8'h48);
    push_byte(8'h65);
    start_tx();
    b = mq.pop_front();
    check_frame(b, "f48", none, none);
    b = mq.pop_front();
    check_frame(b, "f65", none, none);
    chk("b2b_busy_end", {31'h0, tx_busy_o}, 32'h0);
    chk("b2b_tx_end", {31'h0, tx_o}, 32'h1);
    bus_read(A_STAT, exp_stat(1'b0), "b2b_status");
    bus_read(A_CTRL, 32'h1, "b2b_ctrl");

    // Overflow, sticky W1C, read-during-write, decode holes
    bus_write(A_CTRL, 32'h0);
    for (int i = 0; i < 5; i++) push_byte(8'($urandom_range(0, 255)));
    bus_read(A_STAT, exp_stat(1'b0), "ovf_status");
    bus_write(32'hB000_0004, 32'h11);
    bus_write(32'hA000_0014, 32'h11);
    bus_read(A_STAT, exp_stat(1'b0), "unsel_wr_ignored");
    bus_read(A_DATA, 32'h0, "data_reads_zero");
    bus_read(A_RSVD, 32'h0, "rsvd_reads_zero");
    bus_read(32'hB000_0008, 32'h0, "unsel_read_zero");
    bus.mem_addr = A_STAT; bus.mem_write_data = 32'h800;
    bus.mem_write_en = 1'b1; bus.mem_read_en = 1'b1;
    tick();
    bus.mem_write_en = 1'b0; bus.mem_read_en = 1'b0;
    chk("rw_same_cycle_prewrite", bus.mem_read_data, exp_stat(1'b0));
    m_ovf = 1'b0;
    bus_read(A_STAT, exp_stat(1'b0), "ovf_cleared");

    // Flush while idle, then flush mid-frame
    bus_write(A_CTRL, 32'h2);
    mq.delete();
    bus_read(A_STAT, exp_stat(1'b0), "flush_idle_status");
    bus_read(A_CTRL, 32'h0, "flush_reads_zero");
    for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(0, 255)));
    start_tx();
    b = mq.pop_front();
    check_frame(b, "fflush", mk_act(14, 1, A_CTRL, 32'h3), none);
    mq.delete();
    lows = 0;
    for (int i = 0; i < 3 * C; i++) begin
      if (tx_o !== 1'b1) lows++;
      tick();
    end
    chk("flush_no_more_frames", lows, 0);
    chk("flush_busy", {31'h0, tx_busy_o}, 32'h0);
    bus_read(A_STAT, exp_stat(1'b0), "flush_status");

    // Push in the same cycle as the STOP->START pop with the FIFO full
    bus_write(A_CTRL, 32'h0);
    for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 255)));
    bus_read(A_STAT, exp_stat(1'b0), "full_status");
    start_tx();
    b = mq.pop_front();
    e = 8'($urandom_range(0, 255));
    f = 8'($urandom_range(0, 255));
    mq.push_back(e);
    check_frame(b, "fpp0", mk_act(5, 1, A_DATA, {24'h0, e}),
                mk_act(10 * C - 1, 1, A_DATA, {24'h0, f}));
    b = mq.pop_front();
    mq.push_back(f);
    check_frame(b, "fpp1", mk_act(2, 2, A_STAT, exp_stat(1'b1)), none);
    b = mq.pop_front();
    // tx_en cleared mid-frame: frame finishes, then the FSM parks in IDLE
    check_frame(b, "fpp2", mk_act(20, 1, A_CTRL, 32'h0), none);
    lows = 0;
    for (int i = 0; i < 3 * C; i++) begin
      if (tx_o !== 1'b1) lows++;
      tick();
    end
    chk("txen_off_idle", lows, 0);
    chk("txen_off_busy", {31'h0, tx_busy_o}, 32'h0);
    bus_read(A_STAT, exp_stat(1'b0), "txen_off_status");
    bus_write(A_CTRL, 32'h2);
    mq.delete();

    // Randomized rounds against the queue model
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) push_byte(8'($urandom_range(0, 255)));
      bus_read(A_STAT, exp_stat(1'b0), $sformatf("rnd%0d_status", r));
      if (m_ovf) begin
        bus_write(A_STAT, 32'h800);
        m_ovf = 1'b0;
        bus_read(A_STAT, exp_stat(1'b0), $sformatf("rnd%0d_w1c", r));
      end
      start_tx();
      while (mq.size() > 0) begin
        b = mq.pop_front();
        check_frame(b, $sformatf("rnd%0d", r), none, none);
      end
      chk($sformatf("rnd%0d_busy_end", r), {31'h0, tx_busy_o}, 32'h0);
      bus_read(A_STAT, exp_stat(1'b0), $sformatf("rnd%0d_end_status", r));
      bus_write(A_CTRL, 32'h0);
    end

    // Reset in the middle of a frame
    push_byte(8'hA5);
    push_byte(8'h3C);
    start_tx();
    for (int i = 0; i < 10; i++) tick();
    reset_i = 1'b1;
    tick();
    chk("midrst_tx", {31'h0, tx_o}, 32'h1);
    tick();
    reset_i = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    chk("midrst_busy", {31'h0, tx_busy_o}, 32'h0);
    bus_read(A_STAT, 32'h0000_0100, "midrst_status");
    bus_read(A_CTRL, 32'h0, "midrst_ctrl");
    lows = 0;
    for (int i = 0; i < 12 * C; i++) begin
      if (tx_o !== 1'b1) lows++;
      tick();
    end
    chk("midrst_no_residual", lows, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
